// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state encoding and sizing helpers for the adder self-test engine
package adder_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  function automatic int n_vec(input int width);
    return 1 << (2 * width);
  endfunction
  function automatic int settle_w(input int settle);
    return $clog2(settle + 1);
  endfunction
endpackage

// File: rtl/adder_bist_ref.sv
// adder_ref_model: combinational golden adder giving expected sum and carry
module adder_ref_model #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = {1'b0, op_a} + {1'b0, op_b};
endmodule

// File: rtl/adder_bist.sv
// adder_bist: sweeps every operand pair into an adder, checks results, reports errors and first failing vector
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec
);
  localparam int IW = 2 * WIDTH + 1;
  localparam int CW = settle_w(SETTLE_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(n_vec(WIDTH) - 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] exp_sum;
  logic exp_carry, settle_end, launch, mismatch;
  assign op_a = idx[WIDTH-1:0];
  assign op_b = idx[2*WIDTH-1:WIDTH];
  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op_a(op_a),
    .op_b(op_b),
    .sum(exp_sum),
    .carry(exp_carry)
  );
  assign settle_end = cnt == CW'(SETTLE_CYCLES - 1);
  assign launch = (state == IDLE || state == DONE) && start;
  assign mismatch = {dut_carry, dut_sum} != {exp_carry, exp_sum};
  always_comb begin
    state_n = launch ? SETTLE
            : state == SETTLE ? (settle_end ? CHECK : SETTLE)
            : state == CHECK ? (idx == LAST ? DONE : SETTLE)
            : state;
    busy = state == SETTLE || state == CHECK;
    done = state == DONE;
    pass = done && err_count == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        idx        <= '0;
        cnt        <= '0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        fail_vec   <= '0;
      end
      if (state == SETTLE) cnt <= settle_end ? '0 : cnt + CW'(1);
      // DUT outputs are only trusted here, after the settle window
      if (state == CHECK) begin
        if (mismatch) begin
          err_count <= &err_count ? err_count : err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= idx[2*WIDTH-1:0];
          end
        end
        if (idx != LAST) idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: drives two BIST instances against a fault-injectable adder and checks their reports
module tb_adder_bist;
  logic clk = 0, rst = 1, start1 = 0, start2 = 0, sel = 0;
  logic [0:0] opa1, opb1, sum1, fvec1_hi;
  logic [1:0] opa2, opb2, sum2, fvec1, err2;
  logic [3:0] fvec2;
  logic carry1, carry2, busy1, busy2, done1, done2, pass1, pass2, fv1, fv2;
  logic [7:0] err1;
  int mode1 = 0, mode2 = 0, mask1[4], mask2[16];
  int checks = 0, errors = 0;
  logic c_busy, c_done, c_pass, c_fv;
  logic [7:0] c_err;
  logic [3:0] c_fvec;
  logic [1:0] c_opa, c_opb;
  always #5 clk = ~clk;
  adder_bist #(.WIDTH(1), .SETTLE_CYCLES(1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(opa1), .op_b(opb1),
    .dut_sum(sum1), .dut_carry(carry1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
  );
  adder_bist #(.WIDTH(2), .SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(opa2), .op_b(opb2),
    .dut_sum(sum2), .dut_carry(carry2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2)
  );
  assign fvec1_hi = 1'b0;
  assign c_busy = sel ? busy2 : busy1;
  assign c_done = sel ? done2 : done1;
  assign c_pass = sel ? pass2 : pass1;
  assign c_fv   = sel ? fv2 : fv1;
  assign c_err  = sel ? {6'b0, err2} : err1;
  assign c_fvec = sel ? fvec2 : {2'b0, fvec1};
  assign c_opa  = sel ? opa2 : {1'b0, opa1};
  assign c_opb  = sel ? opb2 : {1'b0, opb1};
  // adder under test: ideal sum with a selectable fault applied
  function automatic int dut_out(input bit s, input int mode, input int a, input int b);
    int w = s ? 2 : 1;
    int smask = (1 << w) - 1;
    int ideal = a + b;
    int v = b * (1 << w) + a;
    int r;
    case (mode)
      1: r = ideal | smask;
      2: r = ideal & smask;
      3: r = ideal ^ smask;
      4: r = ideal ^ (s ? mask2[v] : mask1[v]);
      default: r = ideal;
    endcase
    return r & ((1 << (w + 1)) - 1);
  endfunction
  always_comb begin
    int o1, o2;
    o1 = dut_out(1'b0, mode1, int'(opa1), int'(opb1));
    o2 = dut_out(1'b1, mode2, int'(opa2), int'(opb2));
    sum1 = o1[0:0];
    carry1 = o1[1];
    sum2 = o2[1:0];
    carry2 = o2[2];
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model(input bit s, input int mode, output int e_err, output int e_fvec, output int e_fv);
    int w = s ? 2 : 1;
    int n = 1 << (2 * w);
    int cnt = 0;
    e_fvec = 0;
    e_fv = 0;
    for (int v = 0; v < n; v++) begin
      int a = v % (1 << w);
      int b = v / (1 << w);
      if (dut_out(s, mode, a, b) != a + b) begin
        if (cnt == 0) begin
          e_fvec = v;
          e_fv = 1;
        end
        cnt++;
      end
    end
    e_err = cnt > (s ? 3 : 255) ? (s ? 3 : 255) : cnt;
  endtask
  task automatic launch(input bit s);
    @(negedge clk);
    sel = s;
    if (s) start2 = 1; else start1 = 1;
    @(posedge clk);
    #1;
    start1 = 0;
    start2 = 0;
    chk("busy_after_start", c_busy, 1);
    chk("done_after_start", c_done, 0);
    chk("pass_after_start", c_pass, 0);
    chk("err_after_start", c_err, 0);
    chk("fv_after_start", c_fv, 0);
  endtask
  task automatic run(input bit s, input int mode, input int spur, input int e_edges,
                     input int e_err, input int e_fvec, input int e_fv);
    int edges = 0;
    int w = s ? 2 : 1;
    int per = s ? 3 : 2;
    int n = 1 << (2 * w);
    if (s) mode2 = mode; else mode1 = mode;
    launch(s);
    while (!c_done && edges < 200) begin
      if (edges < n * per) begin
        chk("op_a_order", c_opa, (edges / per) % (1 << w));
        chk("op_b_order", c_opb, (edges / per) / (1 << w));
      end
      if (s) start2 = (edges == spur); else start1 = (edges == spur);
      @(posedge clk);
      #1;
      edges++;
    end
    start1 = 0;
    start2 = 0;
    chk("done_edge", edges, e_edges);
    chk("busy_at_done", c_busy, 0);
    chk("err_count", c_err, e_err);
    chk("fail_vec", c_fvec, e_fvec);
    chk("fail_valid", c_fv, e_fv);
    chk("pass", c_pass, e_err == 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", c_done, 1);
  endtask
  typedef struct {
    bit s;
    int mode;
    int spur;
    int edges;
    int err;
    int fvec;
    int fv;
  } vec_t;
  vec_t tbl[6];
  initial begin
    int e_err, e_fvec, e_fv;
    tbl[0] = '{0, 0, -1, 8, 0, 0, 0};
    tbl[1] = '{0, 0, -1, 8, 0, 0, 0};
    tbl[2] = '{0, 1, -1, 8, 2, 0, 1};
    tbl[3] = '{0, 2, 3, 8, 1, 3, 1};
    tbl[4] = '{1, 3, -1, 48, 3, 0, 1};
    tbl[5] = '{1, 0, 7, 48, 0, 0, 0};
    #12;
    chk("reset_busy", busy1 | busy2, 0);
    chk("reset_done", done1 | done2, 0);
    chk("reset_pass", pass1 | pass2, 0);
    chk("reset_err", int'(err1) + int'(err2), 0);
    chk("reset_fv", fv1 | fv2, 0);
    chk("reset_ops", int'(opa1) + int'(opb1) + int'(opa2) + int'(opb2), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++)
      run(tbl[i].s, tbl[i].mode, tbl[i].spur, tbl[i].edges, tbl[i].err, tbl[i].fvec, tbl[i].fv);
    mode1 = 1;
    launch(0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_run_err", err1, 1);
    chk("mid_run_opb", opb1, 1);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_err", err1, 0);
    chk("abort_fv", fv1, 0);
    chk("abort_fvec", fvec1, 0);
    chk("abort_ops", int'(opa1) + int'(opb1), 0);
    @(negedge clk);
    rst = 0;
    run(0, 0, -1, 8, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      bit s = r[0];
      for (int v = 0; v < 16; v++) begin
        mask2[v] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
        if (v < 4) mask1[v] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      model(s, 4, e_err, e_fvec, e_fv);
      run(s, 4, int'($urandom_range(0, s ? 46 : 6)), s ? 48 : 8, e_err, e_fvec, e_fv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Sequential self-test engine; the hardware counterpart of an adder testbench.
- Drives every operand combination into an adder DUT and waits a fixed settle time per vector.
- Checks the DUT's sum/carry against an internal golden model and reports pass/fail, error count and the first failing vector.
- Sits beside Half_adder (WIDTH=1) or wider ripple adders for on-board checking with switches/LEDs.

Parameters:
- WIDTH, 1, operand width of the adder under test; vector count N = 2^(2*WIDTH).
- SETTLE_CYCLES, 1, cycles each vector is held before checking (>=1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; honoured in IDLE or DONE only.
- op_a  output  WIDTH  operand A to DUT.
- op_b  output  WIDTH  operand B to DUT.
- dut_sum  input  WIDTH  DUT sum.
- dut_carry  input  1  DUT carry-out.
- busy  output  1  run in progress.
- done  output  1  run complete, held until next start or reset.
- pass  output  1  done and zero errors.
- err_count  output  ERR_W  mismatching vectors, saturating at 2^ERR_W-1.
- fail_valid  output  1  at least one mismatch seen this run.
- fail_vec  output  2*WIDTH  index of first failing vector.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; idx=0; settle counter=0.
- Vector index idx counts 0..N-1, with op_a = idx[WIDTH-1:0] and op_b = idx[2*WIDTH-1:WIDTH]. Both are registered and change only on idx update.
- Expected value is the (WIDTH+1)-bit result of op_a+op_b: sum = low WIDTH bits, carry = MSB.
- States:
  - IDLE: start=1 -> SETTLE; clear idx, err_count, fail_valid, fail_vec; busy=1.
  - SETTLE: hold the vector SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK (one cycle): compare {dut_carry,dut_sum} with expected at the clock edge.
    - Mismatch: err_count+1 (saturating).
    - First mismatch only: fail_vec=idx, fail_valid=1.
    - If idx==N-1 -> DONE, busy=0, done=1; else idx+1 -> SETTLE.
  - DONE: done=1, and pass=(err_count==0). start=1 -> same actions as start in IDLE (restart; done and pass drop on that edge).
- Latency: done rises N*(SETTLE_CYCLES+1) edges after the edge that samples start.
- start while busy is ignored, with no effect on the run.
- DUT inputs are sampled only in CHECK, so glitches during SETTLE are irrelevant.
- Reset mid-run aborts immediately to the reset state; no partial results are retained.
- idx arithmetic is 2*WIDTH+1 bits wide internally, so the N-1 comparison cannot wrap.

Decomposition:
- Shared package adder_bist_pkg holds:
  - state encoding constants: IDLE, SETTLE, CHECK, DONE;
  - N derivation function;
  - settle-counter width function clog2(SETTLE_CYCLES+1).
- One natural sub-module, adder_ref_model: combinational golden adder, parameter WIDTH, producing expected sum/carry from op_a/op_b.
- FSM, counters and capture logic stay in adder_bist.

Test Plan:
- WIDTH=1, SETTLE=1, correct half adder, start pulse -> vectors (0,0),(1,0),(0,1),(1,1) in order, each held 2 cycles; done=1 exactly 8 edges after start; pass=1, err_count=0, fail_valid=0.
- WIDTH=1, DUT sum stuck-at-1 -> mismatches at idx 0 and 3; err_count=2, fail_vec=0, fail_valid=1, pass=0.
- WIDTH=1, DUT carry stuck-at-0 -> err_count=1, fail_vec=3; start pulsed again at cycle 3 of the run is ignored (done still at edge 8).
- WIDTH=1, rst asserted while idx=2 -> all outputs 0 asynchronously; new start gives a full clean run, pass=1 at edge 8.
- WIDTH=2, SETTLE=2, ERR_W=2, DUT sum inverted -> 16 mismatches; err_count saturates at 3, fail_vec=0; done at edge 48.
- From DONE with pass=1, start pulse -> done and pass drop on the next edge, err_count cleared, run repeats identically.
